request_arbiter: RTL and testbench
==================================

REQUEST_ARBITER -- requirements
Module: request_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 16, maximum owned cycles before forced hand-over when others wait; legal range 2..255.
REQ-003 Port i_clk  input  1  single clock; all state updates on posedge.
REQ-004 Port i_arst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port i_req  input  N_REQ  per-requester request level; held high for the whole transaction.
REQ-006 Port i_rrMode  input  1  1 = round-robin, 0 = fixed priority (index 0 highest).
REQ-007 Port o_gnt  output  N_REQ  one-hot grant, registered; all-zero when idle.
REQ-008 Port o_gntIdx  output  clog2(N_REQ)  binary index of the current owner, registered; 0 when idle.
REQ-009 Port o_busy  output  1  high while any grant is active, registered.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and OWNED (exactly one owner).
REQ-011 IDLE: if any i_req bit is high at an edge, the block SHALL select a winner, enter OWNED and assert o_gnt/o_gntIdx/o_busy from the next cycle (latency 1).
REQ-012 Fixed mode: the winner SHALL be the lowest-index active request.
REQ-013 Round-robin mode: the winner SHALL be the first active request at or after rr pointer, wrapping modulo N_REQ.
REQ-014 On every new grant, the rr pointer SHALL become (winner+1) mod N_REQ, in both modes.
REQ-015 i_rrMode SHALL be sampled only at arbitration edges; a change never revokes a current grant.
REQ-016 OWNED, owner i_req low at an edge: if other requests are pending, the block SHALL grant the next winner at that edge with no idle bubble; otherwise it SHALL return to IDLE, o_gnt = 0.
REQ-017 Hold counter, width clog2(MAX_HOLD+1), SHALL clear on each new grant and increment each owned cycle; it saturates at MAX_HOLD.
REQ-018 Forced hand-over: when the counter equals MAX_HOLD-1 and at least one non-owner request is pending, the block SHALL grant the next winner, excluding the current owner, at that edge.
REQ-019 With no other request pending, the owner SHALL keep the grant indefinitely.
REQ-020 Requests rising while OWNED SHALL NOT affect the owner except through REQ-016/REQ-018.
REQ-021 o_gnt SHALL never have more than one bit set; o_busy SHALL equal the OR of o_gnt.

Reset
REQ-022 Assertion of i_arst_n low SHALL immediately force: state IDLE, o_gnt = 0, o_gntIdx = 0, o_busy = 0, rr pointer 0, hold counter 0.
REQ-023 Reset asserted mid-ownership SHALL drop the grant without completing the hand-over; after release the first arbitration SHALL occur at the first edge with i_arst_n high.

Structure
REQ-024 A shared package SHALL hold the FSM state enum and the default parameter constants.
REQ-025 The winner search (request vector, pointer, exclude mask -> one-hot and index) SHALL be a separate combinational sub-module named rr_pick, reused for both modes (pointer 0 for fixed).
REQ-026 All outputs SHALL be flop outputs; no combinational path from i_req to any output.

Verification
REQ-027 Fixed mode: i_req = 4'b1010 in IDLE -> o_gnt = 4'b0010, o_gntIdx = 1 one cycle later.
REQ-028 Round-robin: i_req = 4'b1111 held, each owner drops its req for one cycle after its grant -> grant order 0,1,2,3,0 with no idle cycle between grants.
REQ-029 Forced hand-over, MAX_HOLD = 4: req0 held, req2 rising at cycle 1 -> o_gnt = 4'b0001 for 4 cycles then 4'b0100.
REQ-030 Lone owner: only req3 high for 40 cycles -> o_gnt = 4'b1000 throughout; counter saturates, no glitch.
REQ-031 Reset mid-ownership: i_arst_n low while o_gnt = 4'b0100 -> all outputs 0 immediately; after release with i_req = 4'b0100 -> grant returns after one edge, rr pointer restarts at 0.
REQ-032 Mode switch: owner holds in round-robin, i_rrMode goes 0, owner releases with i_req = 4'b0011 pending -> next grant = index 0.

Source files
------------

// File: rtl/request_arbiter_pkg.sv
// Shared types and default sizing for the request arbiter.
package request_arbiter_pkg;

    localparam int unsigned DefNReq    = 4;
    localparam int unsigned DefMaxHold = 16;

    typedef enum logic {
        StIdle,
        StOwned
    } arb_state_e;

endpackage

// File: rtl/request_arbiter_rr_pick.sv
// Combinational winner search: first requester at or after i_ptr, skipping i_excl, wrapping.
module rr_pick
    import request_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic [N_REQ-1:0] i_excl,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        int unsigned pos;
        logic [IDX_W-1:0] pos_idx;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = int'(i_ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = IDX_W'(pos);
            if (!o_valid && i_req[pos_idx] && !i_excl[pos_idx]) begin
                o_valid        = 1'b1;
                o_gnt[pos_idx] = 1'b1;
                o_idx          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/request_arbiter.sv
// Single-owner request arbiter with fixed/round-robin selection and a hold limit
// that forces hand-over when other requesters are waiting.
module request_arbiter
    import request_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = DefNReq,
    parameter int unsigned MAX_HOLD = DefMaxHold
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic                       i_rrMode,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [$clog2(N_REQ)-1:0]   o_gntIdx,
    output logic                       o_busy
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

    arb_state_e      state_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [CntW-1:0] hold_cnt_q;

    logic [IdxW-1:0]  pick_ptr;
    logic [N_REQ-1:0] pick_gnt;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_valid;
    logic [IdxW-1:0]  next_ptr;
    logic             owner_req;
    logic             do_grant;
    logic             do_release;

    // Fixed priority is the same search with the pointer pinned to 0.
    assign pick_ptr  = i_rrMode ? rr_ptr_q : '0;
    assign owner_req = |(i_req & o_gnt);
    assign next_ptr  = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + IdxW'(1);

    // The current owner is always excluded; in idle o_gnt is zero so nothing is masked.
    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (pick_ptr),
        .i_excl  (o_gnt),
        .o_gnt   (pick_gnt),
        .o_idx   (pick_idx),
        .o_valid (pick_valid)
    );

    always_comb begin
        do_grant   = 1'b0;
        do_release = 1'b0;
        unique case (state_q)
            StIdle: begin
                do_grant = pick_valid;
            end
            StOwned: begin
                if (!owner_req) begin
                    do_grant   = pick_valid;
                    do_release = !pick_valid;
                end else if (hold_cnt_q == CntW'(MAX_HOLD - 1)) begin
                    do_grant = pick_valid;
                end
            end
            default: begin
                do_grant   = 1'b0;
                do_release = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q    <= StIdle;
            o_gnt      <= '0;
            o_gntIdx   <= '0;
            o_busy     <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else if (do_grant) begin
            state_q    <= StOwned;
            o_gnt      <= pick_gnt;
            o_gntIdx   <= pick_idx;
            o_busy     <= 1'b1;
            rr_ptr_q   <= next_ptr;
            hold_cnt_q <= '0;
        end else if (do_release) begin
            state_q    <= StIdle;
            o_gnt      <= '0;
            o_gntIdx   <= '0;
            o_busy     <= 1'b0;
            hold_cnt_q <= '0;
        end else if (state_q == StOwned && hold_cnt_q != CntW'(MAX_HOLD)) begin
            hold_cnt_q <= hold_cnt_q + CntW'(1);
        end
    end

endmodule

// File: tb/tb_request_arbiter.sv
// Directed bench for request_arbiter: vector table plus multi-cycle corner sequences.
module tb_request_arbiter;

    logic       i_clk;
    logic       i_arst_n;
    logic [3:0] i_req;
    logic       i_rrMode;
    logic [3:0] o_gnt;
    logic [1:0] o_gntIdx;
    logic       o_busy;

    int n_checks;
    int n_pass;

    request_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (4)
    ) dut (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_req    (i_req),
        .i_rrMode (i_rrMode),
        .o_gnt    (o_gnt),
        .o_gntIdx (o_gntIdx),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rr;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei,
                         input logic eb);
        n_checks++;
        if (o_gnt === eg && o_gntIdx === ei && o_busy === eb) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                     name, o_gnt, o_gntIdx, o_busy, eg, ei, eb);
        end
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic rst_n, input logic [3:0] req, input logic rr);
        i_arst_n = rst_n;
        i_req    = req;
        i_rrMode = rr;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        i_arst_n = 1'b0;
        i_req    = '0;
        i_rrMode = 1'b0;

        //            rst   req      rr    gnt      idx  busy
        vecs[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        // Round-robin rotation 0,1,2,3,0 with each owner dropping after its grant
        vecs[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[2]  = '{1'b1, 4'b1110, 1'b1, 4'b0010, 2'd1, 1'b1};
        vecs[3]  = '{1'b1, 4'b1101, 1'b1, 4'b0100, 2'd2, 1'b1};
        vecs[4]  = '{1'b1, 4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1};
        vecs[5]  = '{1'b1, 4'b0111, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[6]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        // Fixed priority 1010 -> index 1, then forced hand-over to 3 after 4 cycles
        vecs[7]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[8]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[9]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[11] = '{1'b1, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1};
        vecs[12] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        // Fixed release straight to next winner; pointer advances in fixed mode too
        vecs[13] = '{1'b1, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[14] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[15] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        // Pointer is 3 here: round-robin wraps past 3 to 0
        vecs[16] = '{1'b1, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[17] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst_n, vecs[i].req, vecs[i].rr);
            check($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].idx, vecs[i].busy);
        end

        // Forced hand-over: req0 held, req2 rises one cycle later
        step(1'b0, 4'b0000, 1'b0);
        check("fh_reset", 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        check("fh_grant0", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0101, 1'b0);
            check($sformatf("fh_hold0_%0d", i), 4'b0001, 2'd0, 1'b1);
        end
        step(1'b1, 4'b0101, 1'b0);
        check("fh_handover", 4'b0100, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0101, 1'b0);
            check($sformatf("fh_hold2_%0d", i), 4'b0100, 2'd2, 1'b1);
        end
        step(1'b1, 4'b0101, 1'b0);
        check("fh_back", 4'b0001, 2'd0, 1'b1);

        // Lone owner keeps the grant well past the hold limit
        step(1'b1, 4'b0000, 1'b0);
        check("lone_idle", 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 4'b1000, 1'b0);
            check($sformatf("lone_%0d", i), 4'b1000, 2'd3, 1'b1);
        end

        // Reset mid-ownership: outputs clear at once, pointer restarts at 0
        step(1'b1, 4'b0100, 1'b0);
        check("rst_owned", 4'b0100, 2'd2, 1'b1);
        #1;
        i_arst_n = 1'b0;
        #1;
        check("rst_async", 4'b0000, 2'd0, 1'b0);
        step(1'b0, 4'b0100, 1'b1);
        check("rst_held", 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b1001, 1'b1);
        check("rst_ptr", 4'b0001, 2'd0, 1'b1);

        // Mode switch while owned: no revoke, next arbitration uses the new mode
        step(1'b1, 4'b0000, 1'b1);
        check("ms_idle", 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0100, 1'b1);
        check("ms_grant", 4'b0100, 2'd2, 1'b1);
        step(1'b1, 4'b0100, 1'b0);
        check("ms_hold", 4'b0100, 2'd2, 1'b1);
        step(1'b1, 4'b1010, 1'b0);
        check("ms_fixed", 4'b0010, 2'd1, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        check("ms_idle2", 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0100, 1'b1);
        check("ms_grant2", 4'b0100, 2'd2, 1'b1);
        step(1'b1, 4'b0100, 1'b0);
        check("ms_hold2", 4'b0100, 2'd2, 1'b1);
        step(1'b1, 4'b0011, 1'b0);
        check("ms_pick0", 4'b0001, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
